// File: rtl/rll_key_loader.sv
// rll_key_loader: serial key intake with XOR checksum for RLL-locked logic.
// Key bytes arrive LSB byte first, one per byte_valid/byte_ready handshake,
// followed by a checksum byte equal to the XOR of all key bytes. Only a
// verified key ever reaches key_out; every other state drives all zeros.
module rll_key_loader #(
  parameter int KEY_WIDTH = 32,  // multiple of 8
  parameter int TIMEOUT   = 255  // idle cycles allowed between bytes; 0 disables
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 err
);

  localparam int NBYTES = KEY_WIDTH / 8;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam int TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] shadow_q;   // key under assembly
  logic [KEY_WIDTH-1:0] key_q;      // verified key presented to the netlist
  logic [CW-1:0]        cnt_q;      // bytes accepted so far in this load
  logic [7:0]           acc_q;      // running XOR of key bytes
  logic [TW-1:0]        tmo_q;      // idle cycles since last transfer

  logic xfer;
  logic last_byte;
  logic cksum_ok;
  logic tmo_hit;

  // Handshake decode and next-state selection; clear overrides everything.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    xfer      = byte_valid && (state_q == LOAD);
    last_byte = (cnt_q == CW'(NBYTES));
    cksum_ok  = (byte_in == acc_q);
    // The idle cycle that would bring the counter to TIMEOUT aborts the load;
    // a transfer in that same cycle keeps the load alive.
    tmo_hit   = (TIMEOUT > 0) && !xfer && (tmo_q == TW'(TIMEOUT - 1));

    unique case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD: begin
        if (xfer && last_byte) state_d = cksum_ok ? ARMED : ERROR;
        else if (tmo_hit)      state_d = ERROR;
      end
      ARMED: if (start) state_d = LOAD;
      ERROR: if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase

    if (clear) state_d = IDLE;
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    byte_ready = (state_q == LOAD);
    busy       = (state_q == LOAD);
    key_valid  = (state_q == ARMED);
    err        = (state_q == ERROR);
    key_out    = key_q;
  end

  // State register plus key assembly, checksum, timeout and key presentation.
  always_ff @(posedge clk) begin
    // NOTE: all state, including the key-holding registers, is reset so a
    // partially loaded key never survives rst.
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      key_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      tmo_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;

      if (clear) begin
        shadow_q <= '0;
        key_q    <= '0;
        cnt_q    <= '0;
        acc_q    <= '0;
        tmo_q    <= '0;
      end else if (state_d == LOAD && state_q != LOAD) begin
        // Entering LOAD erases any previous key, armed or not.
        shadow_q <= '0;
        key_q    <= '0;
        cnt_q    <= '0;
        acc_q    <= '0;
        tmo_q    <= '0;
      end else if (state_q == LOAD) begin
        if (xfer) begin
          tmo_q <= '0;
          if (!last_byte) begin
            for (int k = 0; k < NBYTES; k++) begin
              if (cnt_q == CW'(k)) shadow_q[8*k +: 8] <= byte_in;
            end
            acc_q <= acc_q ^ byte_in;
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end

        if (state_d == ARMED) key_q    <= shadow_q;
        if (state_d == ERROR) shadow_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed bench for rll_key_loader with TIMEOUT = 4.
module tb_rll_key_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clear;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        err;

  int passed = 0;
  int total  = 0;

  rll_key_loader #(.KEY_WIDTH(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clear      (clear),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("ready_in_gap", 32'(byte_ready), 32'd1);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_key"},   key_out,             32'h0);
    check({tag, "_valid"}, 32'(key_valid),      32'd0);
    check({tag, "_ready"}, 32'(byte_ready),     32'd0);
    check({tag, "_busy"},  32'(busy),           32'd0);
    check({tag, "_err"},   32'(err),            32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    outputs_zero("reset");

    // Good load: 70 1F C3 A5, checksum 70^1F^C3^A5 = 09.
    pulse_start();
    check("load_busy",  32'(busy),       32'd1);
    check("load_ready", 32'(byte_ready), 32'd1);
    send(8'h70); send(8'h1F);
    start = 1'b1;            // ignored while loading
    send(8'hC3);
    start = 1'b0;
    send(8'hA5);
    check("partial_key",   key_out,         32'h0);
    check("partial_valid", 32'(key_valid),  32'd0);
    send(8'h09);
    check("good_key",   key_out,         32'hA5C31F70);
    check("good_valid", 32'(key_valid),  32'd1);
    check("good_err",   32'(err),        32'd0);
    check("good_busy",  32'(busy),       32'd0);
    check("good_ready", 32'(byte_ready), 32'd0);
    tick(); tick();
    check("armed_hold", key_out, 32'hA5C31F70);

    // Reload from ARMED erases the old key immediately.
    pulse_start();
    check("reload_key",   key_out,        32'h0);
    check("reload_valid", 32'(key_valid), 32'd0);
    check("reload_busy",  32'(busy),      32'd1);
    send(8'h04); send(8'h03); send(8'h02); send(8'h01); send(8'h04);
    check("reload_new_key",   key_out,        32'h01020304);
    check("reload_new_valid", 32'(key_valid), 32'd1);

    // Bad checksum.
    pulse_start();
    send(8'h70); send(8'h1F); send(8'hC3); send(8'hA5); send(8'h08);
    check("bad_err",   32'(err),       32'd1);
    check("bad_key",   key_out,        32'h0);
    check("bad_valid", 32'(key_valid), 32'd0);
    check("bad_busy",  32'(busy),      32'd0);
    pulse_start();
    check("retry_err_clr", 32'(err), 32'd0);
    send(8'h70); send(8'h1F); send(8'hC3); send(8'hA5); send(8'h09);
    check("retry_key",   key_out,        32'hA5C31F70);
    check("retry_valid", 32'(key_valid), 32'd1);

    // Gaps of 3 idle cycles stay within TIMEOUT = 4.
    pulse_start();
    send(8'h70); idle(3);
    send(8'h1F); idle(3);
    send(8'hC3); idle(3);
    send(8'hA5); idle(3);
    send(8'h09);
    check("gap_key",   key_out,        32'hA5C31F70);
    check("gap_valid", 32'(key_valid), 32'd1);

    // A gap of 4 idle cycles after byte 2 aborts the load.
    pulse_start();
    send(8'h70); send(8'h1F);
    idle(3);
    check("tmo_pre_err",  32'(err),  32'd0);
    check("tmo_pre_busy", 32'(busy), 32'd1);
    tick();
    check("tmo_err",   32'(err),       32'd1);
    check("tmo_key",   key_out,        32'h0);
    check("tmo_valid", 32'(key_valid), 32'd0);
    check("tmo_busy",  32'(busy),      32'd0);

    // clear in the same cycle as a valid byte after 2 bytes.
    pulse_start();
    send(8'h70); send(8'h1F);
    clear = 1'b1;
    send(8'hC3);
    clear = 1'b0;
    outputs_zero("clear");
    tick();
    check("clear_stays_idle", 32'(busy), 32'd0);

    // clear from ARMED zeroizes the presented key.
    pulse_start();
    send(8'h04); send(8'h03); send(8'h02); send(8'h01); send(8'h04);
    check("pre_clear_key", key_out, 32'h01020304);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    outputs_zero("clear_armed");

    // rst after 3 bytes discards the partial key.
    pulse_start();
    send(8'h70); send(8'h1F); send(8'hC3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    outputs_zero("rst_mid");
    pulse_start();
    send(8'h70); send(8'h1F); send(8'hC3); send(8'hA5); send(8'h09);
    check("post_rst_key",   key_out,        32'hA5C31F70);
    check("post_rst_valid", 32'(key_valid), 32'd1);
    check("post_rst_err",   32'(err),       32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
